pwm_drive_sequencer: RTL and testbench
======================================

Name: pwm_drive_sequencer

Overview:
Sits between the PID controller and the two fan/motor drivers. It takes the controller's left/right duty magnitudes and generates mutually exclusive PWM outputs for the two drivers. A side change always ramps the active side to zero and inserts a dead interval before the other side starts. Duty changes are applied only at PWM period boundaries, and a watchdog faults the drive if the controller stops updating.

Parameters:
PWM_PERIOD, 7500, PWM period in Clk cycles; counter runs 0..PWM_PERIOD-1
DUTY_MAX, 7500, saturation limit for commanded duty
DEAD_PERIODS, 2, PWM periods with both outputs low between sides
SLEW_STEP, 500, max change of applied duty per period end
WDOG_PERIODS, 50, period ends without Update before fault

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
Enable  in  1  drive enable; low forces IDLE
Update  in  1  one-cycle strobe: DutyL/DutyR valid
DutyL  in  16  left duty command, unsigned
DutyR  in  16  right duty command, unsigned
PwmL  out  1  left driver PWM, registered
PwmR  out  1  right driver PWM, registered
AppliedDuty  out  16  duty currently applied to the active side
ActiveSide  out  2  00 none, 01 left, 10 right
Fault  out  1  watchdog fault flag
PeriodEnd  out  1  one-cycle pulse when cnt==PWM_PERIOD-1

Behaviour:
- Reset is asynchronous on Rst_n (active-low), clock is Clk. In reset: state IDLE, cnt=0, cmdL=cmdR=0, applied=0, dead_cnt=0, wdog=0. All outputs 0.
- Command latch: on Update, cmdL=min(DutyL,DUTY_MAX) and cmdR=min(DutyR,DUTY_MAX).
- Request decode from the latched cmd registers:
  - cmdL>cmdR → req=L, target=cmdL.
  - cmdR>cmdL → req=R, target=cmdR.
  - Equal → req=none, target=0.
- Timebase: cnt increments every cycle while Enable=1 and wraps at PWM_PERIOD-1. PeriodEnd is high on the wrap cycle. Enable=0 holds cnt at 0.
- All state, applied and dead_cnt changes occur only on PeriodEnd cycles, except Enable=0, Fault entry and reset.
- Update and PeriodEnd in the same cycle: the period-end decision uses the previous cmd values; the new command is used at the next period end.
- States:
  - IDLE: outputs low, applied=0. On PeriodEnd with Enable=1 → DEAD with dead_cnt=0.
  - DEAD: both outputs low, applied=0. dead_cnt increments per PeriodEnd and saturates at DEAD_PERIODS. When dead_cnt==DEAD_PERIODS and req=L → RUN_L; req=R → RUN_R; req=none → stay in DEAD.
  - RUN_L / RUN_R:
    - req equals the current side or none: applied moves toward target by at most SLEW_STEP per PeriodEnd, never overshooting.
    - req is the opposite side: applied moves toward 0 by SLEW_STEP. The PeriodEnd at which applied is already 0 → DEAD with dead_cnt=0.
  - FAULT: outputs low, applied=0, Fault=1. Exits only when Enable=0, going to IDLE with Fault cleared.
- PWM: PwmL <= (state==RUN_L && cnt<applied), registered with 1-cycle latency; PwmR likewise for RUN_R. PwmL and PwmR are never both 1.
- applied==DUTY_MAX==PWM_PERIOD gives an output that is always high.
- Watchdog: wdog increments on PeriodEnd and clears on Update; Update wins if both occur in the same cycle. When wdog reaches WDOG_PERIODS in any state except IDLE → FAULT. wdog is cleared in IDLE.
- Enable=0 in any state: next cycle state=IDLE, applied=0, outputs low, cnt=0.
- ActiveSide: 01 in RUN_L, 10 in RUN_R, otherwise 00.

Optional Feature:
MOTOR_SLEW_EN:
- Defined: slew limiting by SLEW_STEP as described in Behaviour.
- Undefined: at each PeriodEnd applied jumps directly to target, or to 0 on a side change. Opposite-side requests still pass through applied=0 for one period and then DEAD.

Decomposition:
- Package drive_pkg holds:
  - The state enum: IDLE, DEAD, RUN_L, RUN_R, FAULT.
  - Side codes SIDE_NONE=2'b00, SIDE_L=2'b01, SIDE_R=2'b10.
  - The 16-bit duty width constant.
- Sub-module pwm_timebase contains the period counter and PeriodEnd generation. The FSM, slew logic and watchdog stay in the top module.

Test Plan:
Simulation uses PWM_PERIOD=DUTY_MAX=100, SLEW_STEP=20, DEAD_PERIODS=2, WDOG_PERIODS=10.
1. Reset release; Enable=1; Update DutyL=50, DutyR=0 each period → IDLE→DEAD at first PeriodEnd; RUN_L after 2 more; applied 20,40,50 on successive period ends; PwmL high for exactly applied cycles per period; PwmR=0.
2. Update DutyL=300 → cmdL clamped to 100; applied ramps to 100; PwmL continuously high; AppliedDuty=100.
3. From RUN_L applied=50, Update DutyL=0, DutyR=30 → applied 30,10,0; then DEAD for 2 periods with both low and ActiveSide=00; then RUN_R with applied 20,30; PwmL and PwmR never both high.
4. DutyL=DutyR=40 while in RUN_R → target 0; applied ramps to 0; state stays RUN_R.
5. Stop Update for 10 period ends → Fault=1, outputs low. Then Enable=0 → IDLE, Fault=0.
6. Assert Rst_n=0 mid-period in RUN_L → PwmL, AppliedDuty and ActiveSide are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared types for the PWM drive sequencer: FSM states, side codes and duty width.
package drive_pkg;

   localparam int DUTY_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      DEAD,
      RUN_L,
      RUN_R,
      FAULT
   } drive_state_e;

   localparam logic [1:0] SIDE_NONE = 2'b00;
   localparam logic [1:0] SIDE_L    = 2'b01;
   localparam logic [1:0] SIDE_R    = 2'b10;

endpackage

// File: rtl/pwm_timebase.sv
// PWM period counter: runs 0..PWM_PERIOD-1 while enabled, held at 0 otherwise.
module pwm_timebase
   import drive_pkg::*;
#(
   parameter int PWM_PERIOD = 7500
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Enable,
   output logic [DUTY_W-1:0] cnt,
   output logic              period_end
);

   localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_PERIOD - 1);
   localparam logic [DUTY_W-1:0] ONE      = DUTY_W'(1);

   assign period_end = Enable && (cnt == CNT_LAST);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt <= '0;
      end else if (!Enable || period_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + ONE;
      end
   end

endmodule

// File: rtl/pwm_drive_sequencer.sv
// Mutually exclusive left/right PWM drive with dead time, period-aligned duty updates and watchdog.
// Build option MOTOR_SLEW_EN: limit applied-duty change to SLEW_STEP per PWM period.
//
// state | meaning
// IDLE  | drive disabled or just enabled, outputs low
// DEAD  | both outputs low between sides, counting dead periods
// RUN_L | left driver active, applied tracks left target
// RUN_R | right driver active, applied tracks right target
// FAULT | watchdog expired, outputs low until Enable drops
module pwm_drive_sequencer
   import drive_pkg::*;
#(
   parameter int PWM_PERIOD   = 7500,
   parameter int DUTY_MAX     = 7500,
   parameter int DEAD_PERIODS = 2,
   parameter int SLEW_STEP    = 500,
   parameter int WDOG_PERIODS = 50
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Enable,
   input  logic              Update,
   input  logic [DUTY_W-1:0] DutyL,
   input  logic [DUTY_W-1:0] DutyR,
   output logic              PwmL,
   output logic              PwmR,
   output logic [DUTY_W-1:0] AppliedDuty,
   output logic [1:0]        ActiveSide,
   output logic              Fault,
   output logic              PeriodEnd
);

   // Without slew limiting the step bound covers the whole duty range, so every move is a jump.
`ifdef MOTOR_SLEW_EN
   localparam int STEP_LIM = SLEW_STEP;
`else
   localparam int STEP_LIM = (SLEW_STEP > DUTY_MAX) ? SLEW_STEP : DUTY_MAX;
`endif

   localparam logic [DUTY_W-1:0] DUTY_LIM = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0] STEP     = DUTY_W'(STEP_LIM);
   localparam logic [DUTY_W-1:0] DEAD_N   = DUTY_W'(DEAD_PERIODS);
   localparam logic [DUTY_W-1:0] WDOG_N   = DUTY_W'(WDOG_PERIODS);
   localparam logic [DUTY_W-1:0] ONE      = DUTY_W'(1);

   drive_state_e      state, state_nxt;
   logic [DUTY_W-1:0] cmd_l, cmd_r, target;
   logic [DUTY_W-1:0] applied, applied_nxt;
   logic [DUTY_W-1:0] dead_cnt, dead_cnt_nxt, dead_inc;
   logic [DUTY_W-1:0] wdog, wdog_nxt;
   logic [DUTY_W-1:0] cnt;
   logic [1:0]        req;
   logic              period_end, wdog_trip;
   logic              pwm_l, pwm_r;

   pwm_timebase #(
      .PWM_PERIOD (PWM_PERIOD)
   ) u_timebase (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .Enable     (Enable),
      .cnt        (cnt),
      .period_end (period_end)
   );

   function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                     input logic [DUTY_W-1:0] tgt);
      if (cur < tgt) begin
         return ((tgt - cur) > STEP) ? cur + STEP : tgt;
      end
      return ((cur - tgt) > STEP) ? cur - STEP : tgt;
   endfunction

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cmd_l <= '0;
         cmd_r <= '0;
      end else if (Update) begin
         cmd_l <= (DutyL > DUTY_LIM) ? DUTY_LIM : DutyL;
         cmd_r <= (DutyR > DUTY_LIM) ? DUTY_LIM : DutyR;
      end
   end

   always_comb begin
      req    = SIDE_NONE;
      target = '0;
      if (cmd_l > cmd_r) begin
         req    = SIDE_L;
         target = cmd_l;
      end else if (cmd_r > cmd_l) begin
         req    = SIDE_R;
         target = cmd_r;
      end
   end

   // Update wins over a coincident period end.
   always_comb begin
      wdog_nxt = wdog;
      if (state == IDLE) begin
         wdog_nxt = '0;
      end else if (Update) begin
         wdog_nxt = '0;
      end else if (period_end && (wdog < WDOG_N)) begin
         wdog_nxt = wdog + ONE;
      end
      wdog_trip = (state != IDLE) && (wdog_nxt >= WDOG_N);
   end

   always_comb begin
      state_nxt    = state;
      applied_nxt  = applied;
      dead_cnt_nxt = dead_cnt;
      dead_inc     = (dead_cnt < DEAD_N) ? dead_cnt + ONE : dead_cnt;
      if (!Enable) begin
         state_nxt    = IDLE;
         applied_nxt  = '0;
         dead_cnt_nxt = '0;
      end else if (wdog_trip) begin
         state_nxt    = FAULT;
         applied_nxt  = '0;
         dead_cnt_nxt = '0;
      end else if (period_end) begin
         case (state)
            IDLE: begin
               state_nxt    = DEAD;
               applied_nxt  = '0;
               dead_cnt_nxt = '0;
            end
            DEAD: begin
               applied_nxt  = '0;
               dead_cnt_nxt = dead_inc;
               if (dead_inc == DEAD_N) begin
                  if (req == SIDE_L) begin
                     state_nxt = RUN_L;
                  end else if (req == SIDE_R) begin
                     state_nxt = RUN_R;
                  end
               end
            end
            RUN_L, RUN_R: begin
               if ((state == RUN_L && req == SIDE_R) || (state == RUN_R && req == SIDE_L)) begin
                  if (applied == '0) begin
                     state_nxt    = DEAD;
                     dead_cnt_nxt = '0;
                  end else begin
                     applied_nxt = step_toward(applied, '0);
                  end
               end else begin
                  applied_nxt = step_toward(applied, target);
               end
            end
            FAULT: begin
               applied_nxt = '0;
            end
            default: begin
               state_nxt   = IDLE;
               applied_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state    <= IDLE;
         applied  <= '0;
         dead_cnt <= '0;
         wdog     <= '0;
         pwm_l    <= 1'b0;
         pwm_r    <= 1'b0;
      end else begin
         state    <= state_nxt;
         applied  <= applied_nxt;
         dead_cnt <= dead_cnt_nxt;
         wdog     <= wdog_nxt;
         pwm_l    <= Enable && (state == RUN_L) && (cnt < applied);
         pwm_r    <= Enable && (state == RUN_R) && (cnt < applied);
      end
   end

   always_comb begin
      case (state)
         RUN_L:   ActiveSide = SIDE_L;
         RUN_R:   ActiveSide = SIDE_R;
         default: ActiveSide = SIDE_NONE;
      endcase
   end

   assign PwmL        = pwm_l;
   assign PwmR        = pwm_r;
   assign AppliedDuty = applied;
   assign Fault       = (state == FAULT);
   assign PeriodEnd   = period_end;

endmodule

// File: tb/tb_pwm_drive_sequencer.sv
// Directed bench for pwm_drive_sequencer; expected duties follow the MOTOR_SLEW_EN build option.
module tb_pwm_drive_sequencer;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        Enable;
   logic        Update;
   logic [15:0] DutyL;
   logic [15:0] DutyR;
   logic        PwmL;
   logic        PwmR;
   logic [15:0] AppliedDuty;
   logic [1:0]  ActiveSide;
   logic        Fault;
   logic        PeriodEnd;

   int checks   = 0;
   int failures = 0;
   int hi_l, hi_r, both;
   bit keep_alive;

   int t1_ap [4];
   int t1_hi [4];
   int t3_ap [8];
   int t3_side [8];
   int t3_hl [8];
   int t3_hr [8];
   int ap8, ap23, ap_t6;

   pwm_drive_sequencer #(
      .PWM_PERIOD   (100),
      .DUTY_MAX     (100),
      .DEAD_PERIODS (2),
      .SLEW_STEP    (20),
      .WDOG_PERIODS (10)
   ) dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .Enable      (Enable),
      .Update      (Update),
      .DutyL       (DutyL),
      .DutyR       (DutyR),
      .PwmL        (PwmL),
      .PwmR        (PwmR),
      .AppliedDuty (AppliedDuty),
      .ActiveSide  (ActiveSide),
      .Fault       (Fault),
      .PeriodEnd   (PeriodEnd)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Runs to the falling edge just after the next period end, counting PWM high cycles of that period.
   task automatic adv(input string tag);
      bit pe_prev;
      bit done;
      pe_prev = 1'b0;
      done    = 1'b0;
      hi_l    = 0;
      hi_r    = 0;
      both    = 0;
      for (int n = 0; n < 250 && !done; n++) begin
         Update = keep_alive && (n == 3);
         @(negedge Clk);
         if (PwmL === 1'b1) hi_l++;
         if (PwmR === 1'b1) hi_r++;
         if (PwmL === 1'b1 && PwmR === 1'b1) both++;
         if (pe_prev) done = 1'b1;
         pe_prev = (PeriodEnd === 1'b1);
      end
      Update = 1'b0;
      checks++;
      assert (done) else begin
         failures++;
         $error("FAIL %s period_end_timeout observed=0 expected=1", tag);
      end
   endtask

   initial begin
`ifdef MOTOR_SLEW_EN
      t1_ap   = '{20, 40, 50, 50};
      t1_hi   = '{0, 20, 40, 50};
      ap8     = 70;
      t3_ap   = '{30, 10, 0, 0, 0, 0, 20, 30};
      t3_side = '{1, 1, 1, 0, 0, 2, 2, 2};
      t3_hl   = '{50, 30, 10, 0, 0, 0, 0, 0};
      t3_hr   = '{0, 0, 0, 0, 0, 0, 0, 20};
      ap23    = 10;
      ap_t6   = 40;
`else
      t1_ap   = '{50, 50, 50, 50};
      t1_hi   = '{0, 50, 50, 50};
      ap8     = 100;
      t3_ap   = '{0, 0, 0, 0, 30, 30, 30, 30};
      t3_side = '{1, 0, 0, 2, 2, 2, 2, 2};
      t3_hl   = '{50, 0, 0, 0, 0, 0, 0, 0};
      t3_hr   = '{0, 0, 0, 0, 0, 30, 30, 30};
      ap23    = 0;
      ap_t6   = 50;
`endif
      Rst_n      = 1'b0;
      Enable     = 1'b0;
      Update     = 1'b0;
      DutyL      = 16'd0;
      DutyR      = 16'd0;
      keep_alive = 1'b0;
      repeat (3) @(negedge Clk);
      check("rst_pwml", PwmL, 0);
      check("rst_pwmr", PwmR, 0);
      check("rst_applied", AppliedDuty, 0);
      check("rst_side", ActiveSide, 0);
      check("rst_fault", Fault, 0);
      check("rst_pe", PeriodEnd, 0);

      // Left command of 50: idle, two dead periods, then ramp.
      Rst_n      = 1'b1;
      Enable     = 1'b1;
      DutyL      = 16'd50;
      DutyR      = 16'd0;
      keep_alive = 1'b1;
      adv("t1_pe1");
      check("t1_dead_side", ActiveSide, 0);
      check("t1_dead_applied", AppliedDuty, 0);
      check("t1_pe_pulse", PeriodEnd, 0);
      adv("t1_pe2");
      check("t1_still_dead", ActiveSide, 0);
      adv("t1_pe3");
      check("t1_run_side", ActiveSide, 1);
      check("t1_run_applied0", AppliedDuty, 0);
      for (int i = 0; i < 4; i++) begin
         adv($sformatf("t1_ramp%0d", i));
         check($sformatf("t1_applied%0d", i), AppliedDuty, t1_ap[i]);
         check($sformatf("t1_hi_l%0d", i), hi_l, t1_hi[i]);
         check($sformatf("t1_hi_r%0d", i), hi_r, 0);
      end

      // Oversized command clamps to full scale: output continuously high.
      DutyL = 16'd300;
      adv("t2_pe8");
      check("t2_applied8", AppliedDuty, ap8);
      adv("t2_pe9");
      adv("t2_pe10");
      check("t2_applied_max", AppliedDuty, 100);
      adv("t2_pe11");
      check("t2_hi_l_full", hi_l, 100);
      check("t2_hi_r", hi_r, 0);
      check("t2_applied_hold", AppliedDuty, 100);

      // Back to 50, then side change to right 30.
      DutyL = 16'd50;
      repeat (3) adv("t3_settle");
      check("t3_applied50", AppliedDuty, 50);
      check("t3_side_l", ActiveSide, 1);
      DutyL = 16'd0;
      DutyR = 16'd30;
      for (int i = 0; i < 8; i++) begin
         adv($sformatf("t3_step%0d", i));
         check($sformatf("t3_applied%0d", i), AppliedDuty, t3_ap[i]);
         check($sformatf("t3_side%0d", i), ActiveSide, t3_side[i]);
         check($sformatf("t3_hi_l%0d", i), hi_l, t3_hl[i]);
         check($sformatf("t3_hi_r%0d", i), hi_r, t3_hr[i]);
         check($sformatf("t3_excl%0d", i), both, 0);
      end

      // Equal commands: target 0, side retained.
      DutyL = 16'd40;
      DutyR = 16'd40;
      adv("t4_pe1");
      check("t4_applied1", AppliedDuty, ap23);
      adv("t4_pe2");
      adv("t4_pe3");
      check("t4_applied0", AppliedDuty, 0);
      check("t4_side_r", ActiveSide, 2);

      // Watchdog: no updates from here on.
      keep_alive = 1'b0;
      repeat (8) adv("t5_quiet");
      check("t5_no_fault_yet", Fault, 0);
      check("t5_side_before", ActiveSide, 2);
      adv("t5_trip");
      check("t5_fault", Fault, 1);
      check("t5_side", ActiveSide, 0);
      check("t5_applied", AppliedDuty, 0);
      @(negedge Clk);
      check("t5_pwml", PwmL, 0);
      check("t5_pwmr", PwmR, 0);
      Enable = 1'b0;
      @(negedge Clk);
      check("t5_fault_clear", Fault, 0);
      check("t5_idle_side", ActiveSide, 0);
      check("t5_idle_pe", PeriodEnd, 0);

      // Asynchronous reset while the left output is high.
      Enable     = 1'b1;
      DutyL      = 16'd50;
      DutyR      = 16'd0;
      keep_alive = 1'b1;
      repeat (3) adv("t6_start");
      check("t6_side_l", ActiveSide, 1);
      repeat (2) adv("t6_ramp");
      check("t6_applied", AppliedDuty, ap_t6);
      keep_alive = 1'b0;
      repeat (10) @(negedge Clk);
      check("t6_pwml_high", PwmL, 1);
      #2;
      Rst_n = 1'b0;
      #1;
      check("t6_rst_pwml", PwmL, 0);
      check("t6_rst_pwmr", PwmR, 0);
      check("t6_rst_applied", AppliedDuty, 0);
      check("t6_rst_side", ActiveSide, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
